// File: rtl/phys_tag_fifo_pkg.sv
// Shared rename-stage types: physical tag width and default register counts.
package rename_pkg;
  localparam int NUM_PHYS_DEF  = 128;
  localparam int ARCH_REGS_DEF = 32;
  localparam int TAG_W         = $clog2(NUM_PHYS_DEF) + 1;

  typedef logic [TAG_W-1:0] phys_tag_t;
endpackage

// File: rtl/phys_tag_fifo_if.sv
// Rename <-> free-list handshake. The err output exists only when TAG_FIFO_CHECK_EN is defined.
interface phys_tag_fifo_if;
  import rename_pkg::*;

  phys_tag_t write_tag_source;
  logic      write_tag;
  phys_tag_t read_tag_dest_0;
  phys_tag_t read_tag_dest_1;
  logic      read_1_tag;
  logic      read_2_tags;
  phys_tag_t freespace;
  phys_tag_t num_items;
`ifdef TAG_FIFO_CHECK_EN
  logic      err;

  modport master (output write_tag_source, write_tag, read_1_tag, read_2_tags,
                  input  read_tag_dest_0, read_tag_dest_1, freespace, num_items, err);
  modport slave  (input  write_tag_source, write_tag, read_1_tag, read_2_tags,
                  output read_tag_dest_0, read_tag_dest_1, freespace, num_items, err);
`else
  modport master (output write_tag_source, write_tag, read_1_tag, read_2_tags,
                  input  read_tag_dest_0, read_tag_dest_1, freespace, num_items);
  modport slave  (input  write_tag_source, write_tag, read_1_tag, read_2_tags,
                  output read_tag_dest_0, read_tag_dest_1, freespace, num_items);
`endif
endinterface

// File: rtl/phys_tag_fifo.sv
// Free list of physical register tags: two-wide pop, one-wide push, occupancy counters.
// Optional sticky misuse flag (err) is compiled in with TAG_FIFO_CHECK_EN.
module phys_tag_fifo
  import rename_pkg::*;
#(
  parameter int NUM_PHYS  = NUM_PHYS_DEF,
  parameter int ARCH_REGS = ARCH_REGS_DEF
) (
  input  logic           clk,
  input  logic           reset,
  phys_tag_fifo_if.slave bus
);
  localparam int TW = $clog2(NUM_PHYS) + 1;
  localparam int PW = $clog2(NUM_PHYS);

  typedef logic [TW-1:0] tag_t;
  typedef logic [PW-1:0] ptr_t;

  tag_t       mem [NUM_PHYS];
  ptr_t       head;
  ptr_t       tail;
  tag_t       count;
  logic [1:0] pop_cnt;
  tag_t       after_pop;
  logic       push_ok;

  // Explicit modulo so non-power-of-two depths wrap correctly.
  function automatic ptr_t ptr_inc(input ptr_t p, input int n);
    int s;
    s = int'(p) + n;
    if (s >= NUM_PHYS) s = s - NUM_PHYS;
    return ptr_t'(s);
  endfunction

  always_comb begin
    pop_cnt = 2'd0;
    if (bus.read_2_tags && count >= tag_t'(2))
      pop_cnt = 2'd2;
    else if ((bus.read_1_tag || bus.read_2_tags) && count >= tag_t'(1))
      pop_cnt = 2'd1;
    after_pop = count - tag_t'(pop_cnt);
    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    push_ok   = bus.write_tag && (after_pop < tag_t'(NUM_PHYS));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_PHYS; i++)
        mem[i] <= (i < NUM_PHYS - ARCH_REGS) ? tag_t'(ARCH_REGS + i) : '0;
      head  <= '0;
      tail  <= ptr_t'((NUM_PHYS - ARCH_REGS) % NUM_PHYS);
      count <= tag_t'(NUM_PHYS - ARCH_REGS);
    end else begin
      if (push_ok) begin
        mem[tail] <= bus.write_tag_source;
        tail      <= ptr_inc(tail, 1);
      end
      head  <= ptr_inc(head, int'(pop_cnt));
      count <= after_pop + tag_t'(push_ok);
    end
  end

  assign bus.read_tag_dest_0 = mem[head];
  assign bus.read_tag_dest_1 = mem[ptr_inc(head, 1)];
  assign bus.num_items       = count;
  assign bus.freespace       = tag_t'(NUM_PHYS) - count;

`ifdef TAG_FIFO_CHECK_EN
  logic err_q;
  logic overflow;
  logic underflow;
  logic bad_tag;

  always_comb begin
    overflow  = bus.write_tag && !push_ok;
    underflow = (bus.read_2_tags && count < tag_t'(2)) ||
                (bus.read_1_tag && !bus.read_2_tags && count == '0);
    bad_tag   = bus.write_tag && (bus.write_tag_source >= tag_t'(NUM_PHYS) ||
                                  bus.write_tag_source <  tag_t'(ARCH_REGS));
  end

  always_ff @(posedge clk) begin
    if (reset)
      err_q <= 1'b0;
    else if (overflow || underflow || bad_tag)
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`endif
endmodule

// File: tb/tb_phys_tag_fifo.sv
// Self-checking bench for phys_tag_fifo: fixed vectors plus a queue scoreboard of free tags.
module tb_phys_tag_fifo;
  localparam int NP = 128;
  localparam int AR = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   model[$];
  logic err_m = 1'b0;

  always #5 clk = ~clk;

  phys_tag_fifo_if bus ();
  phys_tag_fifo dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct {
    logic       w;
    logic [7:0] src;
    logic       r1;
    logic       r2;
    int         num;
    int         d0;
    int         d1;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.write_tag = 1'b0; bus.read_1_tag = 1'b0; bus.read_2_tags = 1'b0;
    bus.write_tag_source = '0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model.delete();
    for (int i = AR; i < NP; i++) model.push_back(i);
    err_m = 1'b0;
  endtask

  // One clock: peeks are compared against the scoreboard head before the edge,
  // counters against the scoreboard size after it.
  task automatic step(input logic w, input logic [7:0] src, input logic r1, input logic r2);
    int n, pops;
    n = model.size();
    pops = (r2 && n >= 2) ? 2 : (((r1 || r2) && n >= 1) ? 1 : 0);
    bus.write_tag = w; bus.write_tag_source = src;
    bus.read_1_tag = r1; bus.read_2_tags = r2;
    #1;
    if (pops >= 1) chk("peek0", int'(bus.read_tag_dest_0), model[0]);
    if (pops == 2) chk("peek1", int'(bus.read_tag_dest_1), model[1]);
    for (int k = 0; k < pops; k++) void'(model.pop_front());
    if (w && (n - pops) < NP) model.push_back(int'(src));
    else if (w) err_m = 1'b1;
    if ((r2 && n < 2) || (r1 && !r2 && n < 1)) err_m = 1'b1;
    if (w && (src >= NP || src < AR)) err_m = 1'b1;
    @(posedge clk); #1;
    bus.write_tag = 1'b0; bus.read_1_tag = 1'b0; bus.read_2_tags = 1'b0;
    chk("num_items", int'(bus.num_items), model.size());
    chk("freespace", int'(bus.freespace), NP - model.size());
`ifdef TAG_FIFO_CHECK_EN
    chk("err", int'(bus.err), int'(err_m));
`endif
  endtask

  task automatic chk_reset_state();
    chk("rst_num", int'(bus.num_items), 96);
    chk("rst_free", int'(bus.freespace), 32);
    chk("rst_d0", int'(bus.read_tag_dest_0), 'h20);
    chk("rst_d1", int'(bus.read_tag_dest_1), 'h21);
`ifdef TAG_FIFO_CHECK_EN
    chk("rst_err", int'(bus.err), 0);
`endif
  endtask

  initial begin
    vec_t vecs[6];
    int   guard;
    vecs[0] = '{w:1'b0, src:8'h00, r1:1'b1, r2:1'b0, num:95, d0:'h21, d1:'h22};
    vecs[1] = '{w:1'b0, src:8'h00, r1:1'b0, r2:1'b1, num:93, d0:'h23, d1:'h24};
    vecs[2] = '{w:1'b0, src:8'h00, r1:1'b1, r2:1'b1, num:91, d0:'h25, d1:'h26};
    vecs[3] = '{w:1'b1, src:8'h70, r1:1'b0, r2:1'b0, num:92, d0:'h25, d1:'h26};
    vecs[4] = '{w:1'b1, src:8'h71, r1:1'b0, r2:1'b1, num:91, d0:'h27, d1:'h28};
    vecs[5] = '{w:1'b0, src:8'h00, r1:1'b0, r2:1'b0, num:91, d0:'h27, d1:'h28};

    do_reset();
    chk_reset_state();

    foreach (vecs[i]) begin
      step(vecs[i].w, vecs[i].src, vecs[i].r1, vecs[i].r2);
      chk("vec_num", int'(bus.num_items), vecs[i].num);
      chk("vec_d0", int'(bus.read_tag_dest_0), vecs[i].d0);
      chk("vec_d1", int'(bus.read_tag_dest_1), vecs[i].d1);
    end

    // Drain to empty (odd count, so the last read_2_tags pops only one).
    guard = 0;
    while (model.size() > 0 && guard < 200) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      guard++;
    end
    chk("drain_empty", int'(bus.num_items), 0);

    // Underflow leaves state alone.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("underflow_num", int'(bus.num_items), 0);
    chk("underflow_free", int'(bus.freespace), NP);
`ifdef TAG_FIFO_CHECK_EN
    chk("underflow_err", int'(bus.err), 1);
`endif

    step(1'b1, 8'h05, 1'b0, 1'b0);
    chk("push_empty_num", int'(bus.num_items), 1);
    chk("push_empty_d0", int'(bus.read_tag_dest_0), 'h05);
    step(1'b1, 8'h06, 1'b1, 1'b0);
    chk("pushpop_num", int'(bus.num_items), 1);
    chk("pushpop_d0", int'(bus.read_tag_dest_0), 'h06);

    // Fill to full, then overflow and push-with-pop into a full FIFO.
    guard = 0;
    while (model.size() < NP && guard < 200) begin
      step(1'b1, 8'(AR + (guard % (NP - AR))), 1'b0, 1'b0);
      guard++;
    end
    chk("full_num", int'(bus.num_items), NP);
    step(1'b1, 8'h40, 1'b0, 1'b0);
    chk("overflow_num", int'(bus.num_items), NP);
    step(1'b1, 8'h40, 1'b1, 1'b0);
    chk("full_pushpop_num", int'(bus.num_items), NP);
    chk("full_pushpop_free", int'(bus.freespace), 0);

    // Rotate well past the end of the buffer while full.
    for (int i = 0; i < 200; i++) step(1'b1, 8'($urandom_range(AR, NP - 1)), 1'b1, 1'b0);
    guard = 0;
    while (model.size() > 0 && guard < 200) begin
      step(1'b0, 8'h00, 1'b0, 1'b1);
      guard++;
    end
    chk("wrap_drain_empty", int'(bus.num_items), 0);

    // Random mix of push/pop traffic.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), 8'($urandom_range(AR, NP - 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset in the middle of a drain.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("mid_drain_num", int'(bus.num_items), 86);
    do_reset();
    chk_reset_state();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
